// File: rtl/mips_pkg.sv
// Shared MIPS front-end types: fetch buffer entry, fetch FSM states, opcode/funct codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_entry_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: imem req/ack port, decode valid/ready head port, redirect input.
// Latency: n/a (wiring only).
// Backpressure: imem_ack throttles fetch; id_ready throttles the instruction head.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  logic [4:0]  id_rt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // fetch stage side
  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output id_valid, id_instr, id_pc, id_opcode, id_funct, id_rt,
    input  id_ready, redirect_valid, redirect_pc
  );

  // memory + decode side
  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  id_valid, id_instr, id_pc, id_opcode, id_funct, id_rt,
    output id_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/if_ibuf.sv
// Instruction buffer: sync FIFO of {pc,instr} with a redirect flush that can keep the entry behind the head.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: caller must not push when full without a same-cycle pop; count/count_nxt let it decide.
module if_ibuf
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  if_entry_t     push_dat,
  input  logic          pop,
  input  logic          flush,
  input  logic          keep_next,
  output if_entry_t     head,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt
);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW-1:0] wr_base;
  logic [AW-1:0] wr_nxt;
  logic          keep;
  if_entry_t     mem [DEPTH];

  // Flush always accompanies a head pop; it rewinds the write pointer to just
  // past the (optionally kept) next entry so younger entries are forgotten.
  always_comb begin
    keep    = flush && keep_next && (count > CW'(1));
    rd_nxt  = rd_ptr + AW'(pop);
    wr_base = flush ? (rd_nxt + AW'(keep)) : wr_ptr;
    wr_nxt  = wr_base + AW'(push);
    if (flush) count_nxt = CW'(keep) + CW'(push);
    else       count_nxt = count + CW'(push) - CW'(pop);
  end

  // Pointer and occupancy state; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_nxt;
      count  <= count_nxt;
    end
  end

  // Storage array; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_base] <= push_dat;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction fetch: PC, one-outstanding imem req/ack, instruction buffer, redirect handling.
// Latency: word returned by ack is at the decode head the next cycle; zero-wait memory sustains 1 instr/cycle.
// Backpressure: id_ready low fills the buffer, then no further request is issued. Macro IF_DELAY_SLOT_EN keeps the branch delay slot.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          IBUF_DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  if_fetch_stage_if.master  bus
);

  localparam int CW = $clog2(IBUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IBUF_DEPTH);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [31:0]   pc;
  logic [31:0]   pc_nxt;
  logic [31:0]   stale_addr;
  logic [31:0]   target;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  if_entry_t     head;
  if_entry_t     head_q;
  if_entry_t     push_dat;
  logic          has_head;
  logic          pop;
  logic          redir;
  logic          ack_req;
  logic          push;
  logic          drop_stale;
  logic          load_target;
  logic          keep_next;

  assign has_head = (count != '0);
  assign pop      = has_head && bus.id_ready;
  assign redir    = bus.redirect_valid && pop;
  assign target   = word_align(bus.redirect_pc);
  assign ack_req  = (state == S_REQ) && bus.imem_ack;
  assign push_dat = '{pc: pc, instr: bus.imem_rdata};

`ifdef IF_DELAY_SLOT_EN
  logic        kept_slot;
  logic        ds_defer;
  logic        ds_fill;
  logic        ds_pending;
  logic [31:0] redirect_hold;

  // A buffered entry behind the branch is its delay slot; otherwise the word
  // in flight (or the next one issued) becomes the delay slot.
  assign kept_slot   = redir && (count > CW'(1));
  assign ds_defer    = redir && !kept_slot && !ack_req;
  assign ds_fill     = ds_pending && ack_req && !redir;
  assign push        = ack_req && !(redir && kept_slot);
  assign drop_stale  = redir && kept_slot;
  assign load_target = redir && (kept_slot || ack_req);
  assign keep_next   = 1'b1;

  // Remember the branch target until the delay slot has been fetched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ds_pending    <= 1'b0;
      redirect_hold <= '0;
    end else if (ds_defer) begin
      ds_pending    <= 1'b1;
      redirect_hold <= target;
    end else if (ds_fill) begin
      ds_pending    <= 1'b0;
    end
  end
`else
  assign push        = ack_req && !redir;
  assign drop_stale  = redir;
  assign load_target = redir;
  assign keep_next   = 1'b0;
`endif

  if_ibuf #(.DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_dat  (push_dat),
    .pop       (pop),
    .flush     (redir),
    .keep_next (keep_next),
    .head      (head),
    .count     (count),
    .count_nxt (count_nxt)
  );

  // FSM state register; reset abandons any in-flight request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: request only while a slot will be free, ride out stale acks in S_DROP.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (redir ? (count_nxt < DEPTH_C) : (count < DEPTH_C)) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (bus.imem_ack)    state_nxt = (count_nxt < DEPTH_C) ? S_REQ : S_IDLE;
        else if (drop_stale) state_nxt = S_DROP;
      end
      S_DROP: begin
        if (bus.imem_ack)    state_nxt = (count_nxt < DEPTH_C) ? S_REQ : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next PC: redirect target, held target after a delay slot, or sequential.
  always_comb begin
    pc_nxt = pc;
    if (load_target)  pc_nxt = target;
`ifdef IF_DELAY_SLOT_EN
    else if (ds_fill) pc_nxt = redirect_hold;
`endif
    else if (ack_req) pc_nxt = pc + 32'd4;
  end

  // PC register, plus the address of a request being abandoned so it stays stable on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      stale_addr <= RESET_PC;
    end else begin
      pc <= pc_nxt;
      if (state == S_REQ && state_nxt == S_DROP) stale_addr <= pc;
    end
  end

  // Outputs: bus request from state, decode fields from the buffer head (zero when empty).
  always_comb begin
    head_q        = has_head ? head : '0;
    bus.imem_req  = (state != S_IDLE);
    bus.imem_addr = (state == S_DROP) ? stale_addr : pc;
    bus.id_valid  = has_head;
    bus.id_instr  = head_q.instr;
    bus.id_pc     = head_q.pc;
    bus.id_opcode = head_q.instr[31:26];
    bus.id_funct  = head_q.instr[5:0];
    bus.id_rt     = head_q.instr[20:16];
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, streaming, backpressure, wait states, redirects, wrap, async reset.
// Memory model answers every request after wait_n wait cycles with a word derived from its address.
// Decode side is driven step by step; consumed entries are logged for order checks.
module tb_if_fetch_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_fetch_stage_if bus ();

  if_fetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int wait_n = 0;
  int wcnt;
  int acks = 0;
  logic [31:0] log_pc[$];
  logic [31:0] log_instr[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'hFFFF_FFFC) ? 32'h0411_0005 : (a ^ 32'hA5A5_0000);
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);
  assign bus.imem_ack   = bus.imem_req && (wcnt >= wait_n);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           wcnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) wcnt <= wcnt + 1;
    else                                  wcnt <= 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.imem_req && bus.imem_ack) acks++;
      if (bus.id_valid && bus.id_ready) begin
        log_pc.push_back(bus.id_pc);
        log_instr.push_back(bus.id_instr);
      end
      if (bus.redirect_valid) begin
        checks++;
        assert (bus.id_valid && bus.id_ready) else begin
          failures++;
          $error("FAIL redirect_legal observed=%b expected=1", bus.id_valid && bus.id_ready);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    logic [31:0] stale;
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'hBFC0_0000);
    chk("rst_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_instr", bus.id_instr, 32'd0);
    chk("rst_pc", bus.id_pc, 32'd0);
    chk("rst_fields", 32'({bus.id_opcode, bus.id_funct, bus.id_rt}), 32'd0);

    // T1: first fetches back to back with zero-wait memory
    bus.id_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_req", 32'(bus.imem_req), 32'd1);
    chk("t1_addr0", bus.imem_addr, 32'hBFC0_0000);
    chk("t1_valid0", 32'(bus.id_valid), 32'd0);
    @(negedge clk);
    chk("t1_addr1", bus.imem_addr, 32'hBFC0_0004);
    chk("t1_valid1", 32'(bus.id_valid), 32'd1);
    chk("t1_pc1", bus.id_pc, 32'hBFC0_0000);
    chk("t1_instr1", bus.id_instr, mem_word(32'hBFC0_0000));
    @(negedge clk);
    chk("t1_addr2", bus.imem_addr, 32'hBFC0_0008);
    chk("t1_pc2", bus.id_pc, 32'hBFC0_0004);

    // T2: backpressure from a fresh reset
    rst_n = 1'b0;
    bus.id_ready = 1'b0;
    repeat (2) @(negedge clk);
    acks = 0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t2_pushes", 32'(acks), 32'd2);
    chk("t2_req_off", 32'(bus.imem_req), 32'd0);
    chk("t2_valid", 32'(bus.id_valid), 32'd1);
    chk("t2_head", bus.id_pc, 32'hBFC0_0000);
    log_pc.delete();
    log_instr.delete();
    bus.id_ready = 1'b1;
    for (n = 0; n < 30 && log_pc.size() < 4; n++) @(negedge clk);
    chk("t2_drain_timeout", 32'(log_pc.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < log_pc.size()) begin
        chk($sformatf("t2_pc%0d", i), log_pc[i], 32'hBFC0_0000 + 32'(4 * i));
        chk($sformatf("t2_instr%0d", i), log_instr[i], mem_word(32'hBFC0_0000 + 32'(4 * i)));
      end
    end

    // T3: wait states, redirect while a request is pending
    wait_n = 3;
    bus.id_ready = 1'b0;
    for (n = 0; n < 20; n++) begin
      if (bus.id_valid && bus.imem_req && !bus.imem_ack) break;
      @(negedge clk);
    end
    chk("t3_setup_timeout", 32'(n < 20), 32'd1);
    stale = bus.imem_addr;
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h8000_0100;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    log_pc.delete();
    log_instr.delete();
    chk("t3_hold_req", 32'(bus.imem_req), 32'd1);
    chk("t3_hold_addr", bus.imem_addr, stale);
    chk("t3_flushed", 32'(bus.id_valid), 32'd0);
    for (n = 0; n < 20 && bus.imem_addr == stale; n++) @(negedge clk);
    chk("t3_new_addr", bus.imem_addr, 32'h8000_0100);
`ifdef IF_DELAY_SLOT_EN
    for (n = 0; n < 40 && log_pc.size() < 2; n++) @(negedge clk);
    chk("t3_log_timeout", 32'(log_pc.size() >= 2), 32'd1);
    if (log_pc.size() >= 2) begin
      chk("t3_ds_pc", log_pc[0], stale);
      chk("t3_target_pc", log_pc[1], 32'h8000_0100);
      chk("t3_target_instr", log_instr[1], mem_word(32'h8000_0100));
    end
`else
    for (n = 0; n < 40 && log_pc.size() < 1; n++) @(negedge clk);
    chk("t3_log_timeout", 32'(log_pc.size() >= 1), 32'd1);
    if (log_pc.size() >= 1) begin
      chk("t3_target_pc", log_pc[0], 32'h8000_0100);
      chk("t3_target_instr", log_instr[0], mem_word(32'h8000_0100));
    end
`endif

    // T4: branch at 0x100 consumed while 0x104 is buffered behind it
    wait_n = 0;
    for (n = 0; n < 20 && !bus.id_valid; n++) @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0100;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    for (n = 0; n < 20; n++) begin
      if (bus.id_valid && bus.id_pc == 32'h0000_0100) break;
      @(negedge clk);
    end
    bus.id_ready = 1'b0;
    chk("t4_setup_timeout", 32'(n < 20), 32'd1);
    repeat (3) @(negedge clk);
    chk("t4_head", bus.id_pc, 32'h0000_0100);
    chk("t4_full_no_req", 32'(bus.imem_req), 32'd0);
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    log_pc.delete();
    log_instr.delete();
    for (n = 0; n < 20 && log_pc.size() < 2; n++) @(negedge clk);
    chk("t4_log_timeout", 32'(log_pc.size() >= 2), 32'd1);
    if (log_pc.size() >= 2) begin
`ifdef IF_DELAY_SLOT_EN
      chk("t4_first", log_pc[0], 32'h0000_0104);
      chk("t4_second", log_pc[1], 32'h0000_0200);
`else
      chk("t4_first", log_pc[0], 32'h0000_0200);
      chk("t4_second", log_pc[1], 32'h0000_0204);
`endif
    end

    // T5: low address bits ignored, field decode, PC wrap
    for (n = 0; n < 20 && !bus.id_valid; n++) @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    for (n = 0; n < 20; n++) begin
      if (bus.id_valid && bus.id_pc == 32'hFFFF_FFFC) break;
      @(negedge clk);
    end
    bus.id_ready = 1'b0;
    chk("t5_setup_timeout", 32'(n < 20), 32'd1);
    chk("t5_instr", bus.id_instr, 32'h0411_0005);
    chk("t5_opcode", 32'(bus.id_opcode), 32'h01);
    chk("t5_rt", 32'(bus.id_rt), 32'h11);
    chk("t5_funct", 32'(bus.id_funct), 32'h05);
    chk("t5_wrap_addr", bus.imem_addr, 32'h0000_0000);
    chk("t5_wrap_req", 32'(bus.imem_req), 32'd1);
    @(negedge clk);
    bus.id_ready = 1'b1;
    @(negedge clk);
    chk("t5_wrap_pc", bus.id_pc, 32'h0000_0000);
    chk("t5_wrap_instr", bus.id_instr, mem_word(32'h0000_0000));

    // T6: asynchronous reset with a request pending and a buffered entry
    wait_n = 5;
    bus.id_ready = 1'b0;
    for (n = 0; n < 20; n++) begin
      if (bus.id_valid && bus.imem_req && !bus.imem_ack) break;
      @(negedge clk);
    end
    chk("t6_setup_timeout", 32'(n < 20), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req", 32'(bus.imem_req), 32'd0);
    chk("t6_addr", bus.imem_addr, 32'hBFC0_0000);
    chk("t6_valid", 32'(bus.id_valid), 32'd0);
    chk("t6_pc", bus.id_pc, 32'd0);
    chk("t6_instr", bus.id_instr, 32'd0);
    chk("t6_fields", 32'({bus.id_opcode, bus.id_funct, bus.id_rt}), 32'd0);
    @(negedge clk);
    wait_n = 0;
    bus.id_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_refetch_req", 32'(bus.imem_req), 32'd1);
    chk("t6_refetch_addr", bus.imem_addr, 32'hBFC0_0000);
    @(negedge clk);
    chk("t6_refetch_valid", 32'(bus.id_valid), 32'd1);
    chk("t6_refetch_pc", bus.id_pc, 32'hBFC0_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
